// File: rtl/mux2by1.sv
// 2:1 multiplexer with a combinational output and a valid-qualified registered copy.
// Optional select-toggle counter is built when MUX2BY1_SEL_CNT_EN is defined.
module mux2by1 #(
    parameter int N = 1
) (
    input  logic         s,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y,
    input  logic         clk,
    input  logic         rst,
    input  logic         vld_in,
    output logic [N-1:0] y_q,
    output logic         vld_out
`ifdef MUX2BY1_SEL_CNT_EN
    ,
    output logic [15:0]  sel_cnt
`endif
);

    logic [N-1:0] w_y;
    logic [N-1:0] r_y_q;
    logic         r_vld_out;

    // Pure gate path: safe to use as the hold mux in front of a flop.
    assign w_y = s ? b : a;
    assign y   = w_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q     <= '0;
            r_vld_out <= 1'b0;
        end else begin
            if (vld_in) begin
                r_y_q <= w_y;
            end
            r_vld_out <= vld_in;
        end
    end

    assign y_q     = r_y_q;
    assign vld_out = r_vld_out;

`ifdef MUX2BY1_SEL_CNT_EN
    logic        r_s_prev;
    logic [15:0] r_sel_cnt;
    logic        w_toggle;

    assign w_toggle = (s != r_s_prev);

    // Counts edges where s moved since the previous edge; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_prev  <= 1'b0;
            r_sel_cnt <= 16'h0000;
        end else begin
            r_s_prev <= s;
            if (w_toggle && (r_sel_cnt != 16'hFFFF)) begin
                r_sel_cnt <= r_sel_cnt + 16'h0001;
            end
        end
    end

    assign sel_cnt = r_sel_cnt;
`endif

endmodule

// File: tb/tb_mux2by1.sv
// Self-checking bench for mux2by1: N=32 combinational/registered paths, N=1 feedback use,
// and (with MUX2BY1_SEL_CNT_EN defined) the saturating select-toggle counter.
module tb_mux2by1;

    logic        clk;
    logic        rst;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        vld_in;
    logic [31:0] y_q;
    logic        vld_out;

    logic        fb_load;
    logic        fb_q;
    logic        fb_d;
    logic        fb_dd;
    logic        fb_yq;
    logic        fb_vld;

    int          n_vec;
    int          n_err;
    logic [32:0] q_exp[$];
    logic [31:0] m_yq;

`ifdef MUX2BY1_SEL_CNT_EN
    logic [15:0] sel_cnt;
    logic [15:0] fb_sel_cnt;
`endif

    mux2by1 #(.N(32)) u_dut (
        .s       (s),
        .a       (a),
        .b       (b),
        .y       (y),
        .clk     (clk),
        .rst     (rst),
        .vld_in  (vld_in),
        .y_q     (y_q),
        .vld_out (vld_out)
`ifdef MUX2BY1_SEL_CNT_EN
        ,
        .sel_cnt (sel_cnt)
`endif
    );

    // Hold-feedback use: s=load, a=Q, b=D, y feeds the flop below.
    mux2by1 #(.N(1)) u_fb (
        .s       (fb_load),
        .a       (fb_q),
        .b       (fb_d),
        .y       (fb_dd),
        .clk     (clk),
        .rst     (rst),
        .vld_in  (1'b0),
        .y_q     (fb_yq),
        .vld_out (fb_vld)
`ifdef MUX2BY1_SEL_CNT_EN
        ,
        .sel_cnt (fb_sel_cnt)
`endif
    );

    always @(posedge clk) fb_q <= fb_dd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, push the expected registered result, then pop and compare after the edge.
    task automatic step(input string tag, input logic t_rst, input logic t_vld, input logic t_s,
                        input logic [31:0] t_a, input logic [31:0] t_b);
        logic [31:0] exp_y;
        logic [32:0] e;
        @(negedge clk);
        rst = t_rst; vld_in = t_vld; s = t_s; a = t_a; b = t_b;
        exp_y = t_s ? t_b : t_a;
        #1;
        check({tag, ".y"}, y, exp_y);
        if (t_rst)      m_yq = 32'h0;
        else if (t_vld) m_yq = exp_y;
        q_exp.push_back({m_yq, (t_vld & ~t_rst)});
        @(posedge clk);
        #1;
        e = q_exp.pop_front();
        check({tag, ".y_q"}, y_q, e[32:1]);
        check({tag, ".vld_out"}, {31'b0, vld_out}, {31'b0, e[0]});
        $display("step %s rst=%0b vld=%0b s=%0b a=%h b=%h y_q=%h vld_out=%0b",
                 tag, t_rst, t_vld, t_s, t_a, t_b, y_q, vld_out);
    endtask

    initial begin
        n_vec = 0; n_err = 0; m_yq = 32'h0;
        rst = 1'b1; vld_in = 1'b0; s = 1'b0; a = 32'h0; b = 32'h0;
        fb_load = 1'b1; fb_d = 1'b0;

        // Combinational path, no clock edge between the two checks.
        @(negedge clk);
        a = 32'h0000_0011; b = 32'h0000_0019; s = 1'b0;
        #1 check("comb_s0", y, 32'h0000_0011);
        s = 1'b1;
        #1 check("comb_s1", y, 32'h0000_0019);
        $display("comb a=%h b=%h y=%h", a, b, y);

        // Reset for two cycles (vld_in high on the second to prove reset wins), then load.
        step("rst0", 1'b1, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);
        step("rst1", 1'b1, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF);
        step("load", 1'b0, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF);
        step("hold0", 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h0BAD_F00D);
        step("hold1", 1'b0, 1'b0, 1'b1, 32'hCAFE_0001, 32'h0000_0002);

        // Select and data change together.
        step("swap", 1'b0, 1'b1, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A);

        // Mid-stream reset discards the sample; first valid output follows next vld_in.
        step("pre_mid", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0005);
        step("mid_rst", 1'b1, 1'b1, 1'b1, 32'h0, 32'h0000_0005);
        step("post_idle", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0005);
        step("post_vld", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0005);

        for (int i = 0; i < 16; i++) begin
            step("rand", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
        end

        // Feedback flop, N=1.
        @(negedge clk); fb_load = 1'b1; fb_d = 1'b0;
        @(posedge clk); #1 check("fb_init", {31'b0, fb_q}, 32'h0);
        @(negedge clk); fb_load = 1'b0; fb_d = 1'b1;
        #1 check("fb_dd_hold", {31'b0, fb_dd}, 32'h0);
        @(posedge clk); #1 check("fb_hold", {31'b0, fb_q}, 32'h0);
        @(negedge clk); fb_load = 1'b1; fb_d = 1'b1;
        @(posedge clk); #1 check("fb_load", {31'b0, fb_q}, 32'h1);
        @(negedge clk); fb_load = 1'b0; fb_d = 1'b0;
        @(posedge clk); #1 check("fb_hold1", {31'b0, fb_q}, 32'h1);
        $display("feedback q=%0b", fb_q);

`ifdef MUX2BY1_SEL_CNT_EN
        @(negedge clk); rst = 1'b1; vld_in = 1'b0; s = 1'b0;
        @(posedge clk); #1 check("cnt_rst", {16'h0, sel_cnt}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); rst = 1'b0; s = ~s;
            @(posedge clk);
        end
        #1 check("cnt_3", {16'h0, sel_cnt}, 32'h3);
        $display("counter after 3 toggles=%h", sel_cnt);
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk); s = ~s;
            @(posedge clk);
        end
        #1 check("cnt_sat", {16'h0, sel_cnt}, 32'h0000_FFFF);
        @(negedge clk); s = ~s;
        @(posedge clk); #1 check("cnt_sat_hold", {16'h0, sel_cnt}, 32'h0000_FFFF);
        @(negedge clk); rst = 1'b1; s = ~s;
        @(posedge clk); #1 check("cnt_rst_prio", {16'h0, sel_cnt}, 32'h0);
        $display("counter after reset=%h", sel_cnt);
        @(negedge clk); rst = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
